camera_stream_source: RTL and testbench
=======================================

Name: camera_stream_source

Overview:
Transmit-side counterpart of the camera pixel-coordinate tracker. It generates the camera-style stream (active-low hsync_n/vsync_n plus pixel data) that the tracker consumes, reading pixels from a 1-cycle-latency frame-buffer RAM or synthesising a test pattern. It is used as a camera emulator in simulation and on-board loopback, and it drives the receive path directly.

Parameters:
H_ACTIVE, 640, valid pixels per line
V_ACTIVE, 480, active lines per frame
H_BLANK, 160, cycles hsync_n low after each line (>=1)
V_BLANK, 8000, cycles vsync_n low before each frame (>=1)
DATA_W, 10, pixel data width

Ports:
clk  in  1  system clock
arst  in  1  reset; synchronous, active-high, despite the name
enable  in  1  level; start frames / keep streaming
patternSel  in  1  1 = test pattern, 0 = RAM data; sampled at frame start only
rdData  in  DATA_W  RAM read data, valid 1 cycle after rdEn
rdEn  out  1  RAM read strobe
rdAddress  out  19  RAM address of the next pixel to be shown
hsync_n  out  1  active-low line blank
vsync_n  out  1  active-low frame blank
pixelData  out  DATA_W  pixel, valid when hsync_n & vsync_n
frameDone  out  1  1-cycle pulse on the last cycle of a frame
frameCount  out  16  completed frames, wraps 65535->0

Behaviour:
- Reset (sync, priority over all): state IDLE; hsync_n=1, vsync_n=0, rdEn=0, rdAddress=0, frameDone=0, frameCount=0, x=y=0. pixelData=0 in IDLE.
- All outputs except pixelData are registered. pixelData = rdData when the latched patternSel is 0, else a registered pattern value.
- States: IDLE, VBLANK, ACTIVE, HBLANK.
- IDLE: hsync_n=1, vsync_n=0. If enable=1 in cycle t, go to VBLANK in t+1 and latch patternSel.
- VBLANK: exactly V_BLANK cycles; vsync_n=0, hsync_n=1. Then go to ACTIVE.
- ACTIVE: exactly H_ACTIVE cycles; hsync_n=vsync_n=1. x goes 0..H_ACTIVE-1. Then go to HBLANK.
- HBLANK: exactly H_BLANK cycles; hsync_n=0, vsync_n=1.
  - If y < V_ACTIVE-1: y++, go to ACTIVE.
  - Else (last line): frameDone=1 on the final HBLANK cycle, frameCount++ on the same cycle; y=0.
    - If enable=1: go to VBLANK and re-latch patternSel.
    - If enable=0: go to IDLE.
- enable is examined only in IDLE and at the frame boundary. Deasserting enable mid-frame always completes the frame.
- Frame length: V_BLANK + V_ACTIVE*(H_ACTIVE+H_BLANK) cycles, back-to-back while enable stays 1.
- RAM prefetch:
  - rdEn=1 in the cycle before every ACTIVE cycle, i.e. the last VBLANK cycle, the last HBLANK cycle of a non-final line, and every ACTIVE cycle except the last of each line.
  - rdAddress increments by 1 after each issued read. It wraps to 0 after H_ACTIVE*V_ACTIVE-1 and equals y*H_ACTIVE+x of the pixel shown next cycle.
  - rdEn is also asserted in pattern mode; the RAM value is ignored.
- Pattern: pixelData = (x+y) truncated to DATA_W, registered so it aligns with the ACTIVE cycle that displays pixel (x,y).
- Internal counters: x, y 10 bits; blank counter 16 bits (V_BLANK <= 65535).
- A reset mid-frame aborts immediately to IDLE with the reset values above.

Test Plan:
- Timing (params 4/3/2/5), enable held 1 -> per frame: vsync_n low 5 cycles, then 3x{4 valid cycles, hsync_n low 2}. Frame = 23 cycles; frameDone pulses at cycle 23, 46; frameCount=1, 2.
- RAM model returns rdData=addr+100 -> valid pixels read 100..111 in order. rdAddress is 0 on the last VBLANK cycle, and rdEn is never high on the last ACTIVE cycle of a line.
- patternSel=1 -> pixel sequence (x+y): 0,1,2,3 / 1,2,3,4 / 2,3,4,5. Toggling patternSel mid-frame has no effect until the next VBLANK.
- enable dropped at cycle 10 of frame 1 -> frame completes (frameDone at cycle 23), then IDLE with vsync_n=0, hsync_n=1, rdEn=0. Re-enable restarts with rdAddress=0.
- arst pulsed mid-line -> next cycle IDLE, frameCount=0, rdAddress=0, hsync_n=1, vsync_n=0.
- Loopback into the coordinate tracker with default params, 2 frames -> tracker pixelAddress wraps 307199->0 exactly at each frameDone, and x/y match the pattern.

Source files
------------

// File: rtl/camera_stream_source.sv
// Camera-style stream generator: emits vsync_n/hsync_n framing and pixel data read from a
// 1-cycle-latency frame-buffer RAM or a synthesised (x+y) test pattern.
module camera_stream_source #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned V_BLANK  = 8000,
  parameter int unsigned DATA_W   = 10
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              patternSel,
  input  logic [DATA_W-1:0] rdData,
  output logic              rdEn,
  output logic [18:0]       rdAddress,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic [DATA_W-1:0] pixelData,
  output logic              frameDone,
  output logic [15:0]       frameCount
);

  typedef enum logic [1:0] {StIdle, StVblank, StActive, StHblank} state_e;

  localparam logic [15:0] VbLast   = 16'(V_BLANK - 1);
  localparam logic [15:0] HbLast   = 16'(H_BLANK - 1);
  localparam logic [9:0]  HaLast   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  VaLast   = 10'(V_ACTIVE - 1);
  localparam logic [18:0] AddrLast = 19'(H_ACTIVE * V_ACTIVE - 1);

  state_e              st_q, st_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [9:0]          x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic                latch_pat;
  logic                pat_sel_q, pat_sel_d;
  logic [DATA_W-1:0]   pattern_q, pattern_d;
  logic                hsync_n_q, hsync_n_d;
  logic                vsync_n_q, vsync_n_d;
  logic                rd_en_q, rd_en_d;
  logic [18:0]         rd_addr_q, rd_addr_d;
  logic                done_q, done_d;
  logic [15:0]         frame_count_q, frame_count_d;

  // Next-state logic: frame sequencing, blank counter and pixel coordinates.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    latch_pat = 1'b0;
    unique case (st_q)
      StIdle: begin
        cnt_d = '0;
        x_d   = '0;
        y_d   = '0;
        if (enable) begin
          st_d      = StVblank;
          latch_pat = 1'b1;
        end
      end
      StVblank: begin
        if (cnt_q == VbLast) begin
          st_d  = StActive;
          cnt_d = '0;
          x_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StActive: begin
        if (x_q == HaLast) begin
          st_d  = StHblank;
          cnt_d = '0;
        end else begin
          x_d = x_q + 10'd1;
        end
      end
      StHblank: begin
        if (cnt_q == HbLast) begin
          cnt_d = '0;
          x_d   = '0;
          if (y_q != VaLast) begin
            y_d  = y_q + 10'd1;
            st_d = StActive;
          end else begin
            // Frame boundary: the only point besides idle where enable is honoured.
            y_d = '0;
            if (enable) begin
              st_d      = StVblank;
              latch_pat = 1'b1;
            end else begin
              st_d = StIdle;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  // Output next values are decoded from the next state so every output leaves a flop.
  always_comb begin
    hsync_n_d     = (st_d != StHblank);
    vsync_n_d     = (st_d == StActive) || (st_d == StHblank);
    done_d        = (st_d == StHblank) && (cnt_d == HbLast) && (y_d == VaLast);
    frame_count_d = done_d ? frame_count_q + 16'd1 : frame_count_q;
    // Read one cycle ahead of every displayed pixel.
    rd_en_d       = ((st_d == StVblank) && (cnt_d == VbLast)) ||
                    ((st_d == StActive) && (x_d != HaLast)) ||
                    ((st_d == StHblank) && (cnt_d == HbLast) && (y_d != VaLast));
    rd_addr_d     = rd_addr_q;
    if (st_q == StIdle) begin
      rd_addr_d = '0;
    end else if (rd_en_q) begin
      rd_addr_d = (rd_addr_q == AddrLast) ? '0 : rd_addr_q + 19'd1;
    end
    pattern_d     = (st_d == StActive) ? DATA_W'(x_d) + DATA_W'(y_d) : '0;
    pat_sel_d     = latch_pat ? patternSel : pat_sel_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      st_q          <= StIdle;
      cnt_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pat_sel_q     <= 1'b0;
      pattern_q     <= '0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      st_q          <= st_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pat_sel_q     <= pat_sel_d;
      pattern_q     <= pattern_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hsync_n    = hsync_n_q;
  assign vsync_n    = vsync_n_q;
  assign rdEn       = rd_en_q;
  assign rdAddress  = rd_addr_q;
  assign frameDone  = done_q;
  assign frameCount = frame_count_q;
  // RAM data arrives combinationally one cycle after its read; the pattern is pre-registered.
  assign pixelData  = (st_q == StIdle) ? '0 : (pat_sel_q ? pattern_q : rdData);

endmodule

// File: tb/tb_camera_stream_source.sv
// Directed bench for camera_stream_source with a small 4x3 geometry and a 1-cycle RAM model.
module tb_camera_stream_source;

  localparam int HA = 4;
  localparam int VA = 3;
  localparam int HB = 2;
  localparam int VB = 5;
  localparam int DW = 10;
  localparam int FRAME_LEN = VB + VA * (HA + HB);

  logic          clk;
  logic          arst;
  logic          enable;
  logic          patternSel;
  logic [DW-1:0] rdData;
  logic          rdEn;
  logic [18:0]   rdAddress;
  logic          hsync_n;
  logic          vsync_n;
  logic [DW-1:0] pixelData;
  logic          frameDone;
  logic [15:0]   frameCount;

  int checks;
  int failures;
  int exp_frames;

  camera_stream_source #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .H_BLANK (HB),
    .V_BLANK (VB),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .enable    (enable),
    .patternSel(patternSel),
    .rdData    (rdData),
    .rdEn      (rdEn),
    .rdAddress (rdAddress),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .pixelData (pixelData),
    .frameDone (frameDone),
    .frameCount(frameCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-buffer model: data = address + 100, one cycle after the read strobe.
  initial rdData = '0;
  always @(posedge clk) begin
    if (rdEn) rdData <= rdAddress[DW-1:0] + 10'd100;
  end

  // Walks one frame from its first VBLANK cycle, checking every cycle against a model of the
  // stream built from the geometry. Optionally drops enable or toggles patternSel mid-frame.
  task automatic run_frame(input bit pat_mode, input int drop_at, input bit toggle_pat);
    int rd_idx;
    int j, line, pos;
    bit e_vb, e_act, e_hb, e_rd, e_done;
    logic [DW-1:0] e_pix;
    rd_idx = 0;
    for (int k = 1; k <= FRAME_LEN; k++) begin
      @(posedge clk);
      @(negedge clk);
      e_vb = (k <= VB);
      line = 0;
      pos  = 0;
      if (!e_vb) begin
        j    = k - VB - 1;
        line = j / (HA + HB);
        pos  = j % (HA + HB);
      end
      e_act  = !e_vb && (pos < HA);
      e_hb   = !e_vb && (pos >= HA);
      e_done = (k == FRAME_LEN);
      e_rd   = (k == VB) || (e_act && pos < HA - 1) ||
               (e_hb && pos == HA + HB - 1 && line < VA - 1);
      if (e_done) exp_frames++;

      checks++;
      if (vsync_n !== !e_vb) begin
        failures++;
        $display("FAIL vsync_n cyc=%0d got=%b exp=%b", k, vsync_n, !e_vb);
      end
      checks++;
      if (hsync_n !== !e_hb) begin
        failures++;
        $display("FAIL hsync_n cyc=%0d got=%b exp=%b", k, hsync_n, !e_hb);
      end
      checks++;
      if (frameDone !== e_done) begin
        failures++;
        $display("FAIL frameDone cyc=%0d got=%b exp=%b", k, frameDone, e_done);
      end
      checks++;
      if (frameCount !== 16'(exp_frames)) begin
        failures++;
        $display("FAIL frameCount cyc=%0d got=%0d exp=%0d", k, frameCount, exp_frames);
      end
      checks++;
      if (rdEn !== e_rd) begin
        failures++;
        $display("FAIL rdEn cyc=%0d got=%b exp=%b", k, rdEn, e_rd);
      end
      if (e_rd) begin
        checks++;
        if (rdAddress !== 19'(rd_idx)) begin
          failures++;
          $display("FAIL rdAddress cyc=%0d got=%0d exp=%0d", k, rdAddress, rd_idx);
        end
        rd_idx++;
      end
      if (e_act) begin
        e_pix = pat_mode ? DW'(pos + line) : DW'(100 + line * HA + pos);
        checks++;
        if (pixelData !== e_pix) begin
          failures++;
          $display("FAIL pixelData cyc=%0d got=%0d exp=%0d", k, pixelData, e_pix);
        end
      end
      if (k == drop_at) enable = 1'b0;
      if (toggle_pat && k == 10) patternSel = ~patternSel;
    end
  endtask

  task automatic test_reset;
    arst       = 1'b1;
    enable     = 1'b0;
    patternSel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (hsync_n !== 1'b1 || vsync_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_sync got=%b%b exp=10", hsync_n, vsync_n);
    end
    checks++;
    if (rdEn !== 1'b0 || rdAddress !== 19'd0) begin
      failures++;
      $display("FAIL reset_rd got=%b/%0d exp=0/0", rdEn, rdAddress);
    end
    checks++;
    if (frameDone !== 1'b0 || frameCount !== 16'd0 || pixelData !== '0) begin
      failures++;
      $display("FAIL reset_misc got=%b/%0d/%0d exp=0/0/0", frameDone, frameCount, pixelData);
    end
    arst       = 1'b0;
    exp_frames = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Two back-to-back RAM frames, then enable drops early in the second and it still completes.
  task automatic test_timing_ram;
    patternSel = 1'b0;
    enable     = 1'b1;
    run_frame(1'b0, 0, 1'b0);
    run_frame(1'b0, 1, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pattern frame with a mid-frame patternSel toggle that must only take effect next frame.
  task automatic test_pattern;
    patternSel = 1'b1;
    enable     = 1'b1;
    run_frame(1'b1, 0, 1'b1);
    run_frame(1'b0, 1, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_enable_drop;
    patternSel = 1'b0;
    enable     = 1'b1;
    run_frame(1'b0, 10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (vsync_n !== 1'b0 || hsync_n !== 1'b1 || rdEn !== 1'b0 || frameDone !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_drop i=%0d got vs=%b hs=%b rd=%b fd=%b exp 0/1/0/0",
                 i, vsync_n, hsync_n, rdEn, frameDone);
      end
      checks++;
      if (pixelData !== '0) begin
        failures++;
        $display("FAIL idle_pixel i=%0d got=%0d exp=0", i, pixelData);
      end
    end
    enable = 1'b1;
    run_frame(1'b0, 1, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    enable = 1'b1;
    repeat (VB + 3) @(posedge clk);
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (frameCount !== 16'd0 || rdAddress !== 19'd0) begin
      failures++;
      $display("FAIL midreset_cnt got fc=%0d addr=%0d exp 0/0", frameCount, rdAddress);
    end
    checks++;
    if (hsync_n !== 1'b1 || vsync_n !== 1'b0 || rdEn !== 1'b0) begin
      failures++;
      $display("FAIL midreset_sync got hs=%b vs=%b rd=%b exp 1/0/0", hsync_n, vsync_n, rdEn);
    end
    arst       = 1'b0;
    enable     = 1'b0;
    exp_frames = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (vsync_n !== 1'b0 || frameCount !== 16'd0 || pixelData !== '0) begin
      failures++;
      $display("FAIL midreset_idle got vs=%b fc=%0d pix=%0d exp 0/0/0",
               vsync_n, frameCount, pixelData);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_frames = 0;
    arst       = 1'b1;
    enable     = 1'b0;
    patternSel = 1'b0;
    test_reset();
    test_timing_ram();
    test_pattern();
    test_enable_drop();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
